dmem_arbiter: RTL

DMEM_ARBITER -- requirements
Module: dmem_arbiter

---
 rtl/dmem_arbiter_pkg.sv | 30 +++
 rtl/dmem_arbiter_rr_arb2.sv | 18 +
 rtl/dmem_arbiter.sv | 136 +++++++++++++
 3 files changed

// File: rtl/dmem_arbiter_pkg.sv
// Shared definitions for the data-memory arbiter: FSM encoding,
// default IO window base and the IO-region decode helper.
package dmem_arbiter_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_WAIT   = 2'd2,
        ST_RESP   = 2'd3
    } arb_state_t;

    localparam logic [31:0] IO_BASE_DEF = 32'hFFFF_FC00;

    localparam logic PORT_CPU  = 1'b0;
    localparam logic PORT_UART = 1'b1;

    typedef struct packed {
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
    } port_req_t;

    function automatic logic is_io(
        input logic [31:0] addr,
        input logic [31:0] base
    );
        return addr >= base;
    endfunction

endpackage

// File: rtl/dmem_arbiter_rr_arb2.sv
// Two-way round-robin picker; the side not granted last wins a tie.
module rr_arb2 (
    input  logic [1:0] req,
    input  logic       last,
    output logic [1:0] gnt
);

    always_comb begin
        gnt = 2'b00;
        unique case (1'b1)
            (req == 2'b01): gnt = 2'b01;
            (req == 2'b10): gnt = 2'b10;
            (req == 2'b11): gnt = last ? 2'b01 : 2'b10;
            default:        gnt = 2'b00;
        endcase
    end

endmodule

// File: rtl/dmem_arbiter.sv
// Shares one synchronous data memory between the CPU and the UART
// programmer; IO-region addresses are rejected without a memory cycle.
module dmem_arbiter
    import dmem_arbiter_pkg::*;
#(
    parameter int          ADDR_W  = 14,
    parameter int          RD_LAT  = 1,
    parameter logic [31:0] IO_BASE = IO_BASE_DEF
) (
    input  logic              clock,
    input  logic              rst_n,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [31:0]       cpu_addr,
    input  logic [31:0]       cpu_wdata,
    output logic              cpu_ack,
    output logic [31:0]       cpu_rdata,
    output logic              cpu_err,
    input  logic              uart_req,
    input  logic              uart_we,
    input  logic [31:0]       uart_addr,
    input  logic [31:0]       uart_wdata,
    output logic              uart_ack,
    output logic [31:0]       uart_rdata,
    output logic              uart_err,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_we,
    output logic [31:0]       mem_wdata,
    input  logic [31:0]       mem_rdata,
    output logic              grant,
    output logic              busy
);

    localparam logic [1:0] WAIT_INIT = 2'(RD_LAT - 1);

    arb_state_t state;
    port_req_t  cpu_in;
    port_req_t  uart_in;
    port_req_t  sel;
    logic [1:0] req_eff;
    logic [1:0] gnt_sel;
    logic       sel_io;
    logic       lat_we;
    logic       lat_io;
    logic [1:0] wait_cnt;
    logic [31:0] rd_q;

    assign cpu_in  = '{we: cpu_we,  addr: cpu_addr,  wdata: cpu_wdata};
    assign uart_in = '{we: uart_we, addr: uart_addr, wdata: uart_wdata};

    // A port is ignored during its own ack cycle so a requester that
    // drops req on seeing ack is not served twice.
    assign req_eff = {uart_req & ~uart_ack, cpu_req & ~cpu_ack};

    rr_arb2 u_rr (
        .req  (req_eff),
        .last (grant),
        .gnt  (gnt_sel)
    );

    assign sel    = gnt_sel[1] ? uart_in : cpu_in;
    assign sel_io = is_io(sel.addr, IO_BASE);

    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            state      <= ST_IDLE;
            grant      <= PORT_UART;
            busy       <= 1'b0;
            cpu_ack    <= 1'b0;
            cpu_err    <= 1'b0;
            cpu_rdata  <= '0;
            uart_ack   <= 1'b0;
            uart_err   <= 1'b0;
            uart_rdata <= '0;
            mem_addr   <= '0;
            mem_we     <= 1'b0;
            mem_wdata  <= '0;
            lat_we     <= 1'b0;
            lat_io     <= 1'b0;
            wait_cnt   <= '0;
            rd_q       <= '0;
        end else begin
            cpu_ack  <= 1'b0;
            cpu_err  <= 1'b0;
            uart_ack <= 1'b0;
            uart_err <= 1'b0;
            mem_we   <= 1'b0;
            unique case (state)
                ST_IDLE: begin
                    if (|req_eff) begin
                        grant     <= gnt_sel[1];
                        lat_we    <= sel.we;
                        lat_io    <= sel_io;
                        mem_addr  <= sel.addr[ADDR_W+1:2];
                        mem_wdata <= sel.wdata;
                        mem_we    <= sel.we & ~sel_io;
                        rd_q      <= '0;
                        busy      <= 1'b1;
                        state     <= ST_ACCESS;
                    end
                end
                ST_ACCESS: begin
                    if (lat_io || lat_we) begin
                        state <= ST_RESP;
                    end else begin
                        wait_cnt <= WAIT_INIT;
                        state    <= ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    if (wait_cnt == 2'd0) begin
                        rd_q  <= mem_rdata;
                        state <= ST_RESP;
                    end else begin
                        wait_cnt <= wait_cnt - 2'd1;
                    end
                end
                ST_RESP: begin
                    busy  <= 1'b0;
                    state <= ST_IDLE;
                    if (grant == PORT_UART) begin
                        uart_ack   <= 1'b1;
                        uart_err   <= lat_io;
                        uart_rdata <= rd_q;
                    end else begin
                        cpu_ack   <= 1'b1;
                        cpu_err   <= lat_io;
                        cpu_rdata <= rd_q;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule
